// File: rtl/ariane_regfile_pkg.sv
// rtl/ariane_regfile_pkg.sv - shared types and helpers for the LVT register file
//
// Purpose: clear-sequencer state encoding and the live-value-table width helper,
// shared by the register file top level and its bank sub-module.
// Ports: none (package).

package ariane_regfile_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_e;

  // Width of one LVT entry: enough bits to name any write port, never zero.
  function automatic int lvt_width(input int nr_write_ports);
    return (nr_write_ports > 1) ? $clog2(nr_write_ports) : 1;
  endfunction

endpackage

// File: rtl/regfile_lvt_bank.sv
// rtl/regfile_lvt_bank.sv - one distributed-RAM bank of the LVT register file
//
// Purpose: storage for the registers written by a single write port.
// Ports:
//   clk_i  - clock
//   we     - write enable (already qualified by the top level)
//   waddr  - write address, guaranteed in range when we is high
//   wdata  - write data
//   raddr  - NR_READ_PORTS asynchronous read addresses
//   rdata  - NR_READ_PORTS read data words
// No reset: contents are undefined until written.

module regfile_lvt_bank
  import ariane_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned NR_READ_PORTS = 2,
  parameter int unsigned NR_REGS       = 32,
  parameter int unsigned ADDR_W        = 5
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr [NR_READ_PORTS],
  output logic [DATA_WIDTH-1:0] rdata [NR_READ_PORTS]
);

  logic [DATA_WIDTH-1:0] mem [NR_REGS];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range addresses return don't-care data; the top level forces
  // those reads to zero.
  always_comb begin
    for (int k = 0; k < NR_READ_PORTS; k++) begin
      rdata[k] = mem[raddr[k]];
    end
  end

endmodule

// File: rtl/ariane_regfile_lvt.sv
// rtl/ariane_regfile_lvt.sv - multi-write-port register file built from LVT-selected banks
//
// Purpose: register file with one bank per write port and a live-value table
// that records which bank holds the newest copy of each register. Adds an
// optional same-cycle bypass and a clear sequencer that zeroes the file.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   test_en_i     - test enable, functionally unused
//   clear_i       - single-cycle request to zero the whole file
//   busy_o        - clear sequence in progress (writes dropped, reads zero)
//   raddr_i/rdata_o - NR_READ_PORTS combinational read ports
//   waddr_i/wdata_i/we_i - NR_WRITE_PORTS synchronous write ports

module ariane_regfile_lvt
  import ariane_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter int unsigned NR_REGS        = 32,
  parameter bit          ZERO_REG_ZERO  = 1'b0,
  parameter bit          BYPASS         = 1'b1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned ADDR_W        = $clog2(NR_REGS)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      test_en_i,
  input  logic                      clear_i,
  output logic                      busy_o,
  input  logic [ADDR_W-1:0]         raddr_i [NR_READ_PORTS],
  output logic [DATA_WIDTH-1:0]     rdata_o [NR_READ_PORTS],
  input  logic [ADDR_W-1:0]         waddr_i [NR_WRITE_PORTS],
  input  logic [DATA_WIDTH-1:0]     wdata_i [NR_WRITE_PORTS],
  input  logic [NR_WRITE_PORTS-1:0] we_i
);

  localparam int unsigned LOG_W = unsigned'(lvt_width(NR_WRITE_PORTS));
  // One extra bit so NR_REGS itself is representable for the range compare.
  localparam logic [ADDR_W:0]   NR_REGS_W = (ADDR_W + 1)'(NR_REGS);
  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NR_REGS - 1);

  logic unused_test_en;
  assign unused_test_en = test_en_i;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NR_REGS_W) && !(ZERO_REG_ZERO && (a == '0));
  endfunction

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_we;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt_q == LAST_REG) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state_q is itself a flop, so busy_o is registered.
  assign busy_o = (state_q == CLEAR);

  // ---------------------------------------------------------------------------
  // Write qualification
  // ---------------------------------------------------------------------------
  logic [NR_WRITE_PORTS-1:0] wvalid;

  always_comb begin
    wvalid = '0;
    for (int j = 0; j < NR_WRITE_PORTS; j++) begin
      wvalid[j] = we_i[j] && addr_ok(waddr_i[j]) && !busy_o;
    end
  end

  // ---------------------------------------------------------------------------
  // Live-value table
  // ---------------------------------------------------------------------------
  logic [LOG_W-1:0] lvt_q [NR_REGS];

  // Ports are visited in ascending order so the highest-index writer to an
  // address issues the last non-blocking assignment and wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NR_REGS; r++) begin
        lvt_q[r] <= '0;
      end
    end else begin
      if (clr_we) begin
        lvt_q[clr_cnt_q] <= '0;
      end
      for (int j = 0; j < NR_WRITE_PORTS; j++) begin
        if (wvalid[j]) begin
          lvt_q[waddr_i[j]] <= LOG_W'(j);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Banks
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] bank_rdata [NR_WRITE_PORTS][NR_READ_PORTS];

  for (genvar j = 0; j < NR_WRITE_PORTS; j++) begin : g_bank
    logic                  bank_we;
    logic [ADDR_W-1:0]     bank_waddr;
    logic [DATA_WIDTH-1:0] bank_wdata;

    if (j == 0) begin : g_clr_mux
      // User writes are dropped while clearing, so the sequencer owns bank 0.
      assign bank_we    = clr_we | wvalid[0];
      assign bank_waddr = clr_we ? clr_cnt_q : waddr_i[0];
      assign bank_wdata = clr_we ? '0 : wdata_i[0];
    end else begin : g_user
      assign bank_we    = wvalid[j];
      assign bank_waddr = waddr_i[j];
      assign bank_wdata = wdata_i[j];
    end

    regfile_lvt_bank #(
      .DATA_WIDTH   (DATA_WIDTH),
      .NR_READ_PORTS(NR_READ_PORTS),
      .NR_REGS      (NR_REGS),
      .ADDR_W       (ADDR_W)
    ) u_bank (
      .clk_i(clk_i),
      .we   (bank_we),
      .waddr(bank_waddr),
      .wdata(bank_wdata),
      .raddr(raddr_i),
      .rdata(bank_rdata[j])
    );
  end

  // ---------------------------------------------------------------------------
  // Read path: LVT select, bypass, forced zero
  // ---------------------------------------------------------------------------
  logic [LOG_W-1:0]      rd_sel  [NR_READ_PORTS];
  logic [DATA_WIDTH-1:0] rd_data [NR_READ_PORTS];
  logic                  rd_ok   [NR_READ_PORTS];

  always_comb begin
    for (int k = 0; k < NR_READ_PORTS; k++) begin
      rd_ok[k]   = addr_ok(raddr_i[k]);
      rd_sel[k]  = rd_ok[k] ? lvt_q[raddr_i[k]] : '0;
      rd_data[k] = '0;
      for (int j = 0; j < NR_WRITE_PORTS; j++) begin
        if (rd_sel[k] == LOG_W'(j)) begin
          rd_data[k] = bank_rdata[j][k];
        end
      end
      if (BYPASS) begin
        for (int j = 0; j < NR_WRITE_PORTS; j++) begin
          if (wvalid[j] && (waddr_i[j] == raddr_i[k])) begin
            rd_data[k] = wdata_i[j];
          end
        end
      end
      rdata_o[k] = (rd_ok[k] && !busy_o) ? rd_data[k] : '0;
    end
  end

endmodule

// File: tb/tb_ariane_regfile_lvt.sv
// tb/tb_ariane_regfile_lvt.sv - directed self-checking bench for ariane_regfile_lvt

module tb_ariane_regfile_lvt;

  localparam int DW = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n;

  // DUT a: defaults
  logic          clear_a, busy_a;
  logic [AW-1:0] raddr_a [2];
  logic [DW-1:0] rdata_a [2];
  logic [AW-1:0] waddr_a [2];
  logic [DW-1:0] wdata_a [2];
  logic [1:0]    we_a;
  // DUT b: no bypass
  logic          clear_b, busy_b;
  logic [AW-1:0] raddr_b [2];
  logic [DW-1:0] rdata_b [2];
  logic [AW-1:0] waddr_b [2];
  logic [DW-1:0] wdata_b [2];
  logic [1:0]    we_b;
  // DUT c: 24 registers, register 0 hard-wired
  logic          clear_c, busy_c;
  logic [AW-1:0] raddr_c [2];
  logic [DW-1:0] rdata_c [2];
  logic [AW-1:0] waddr_c [2];
  logic [DW-1:0] wdata_c [2];
  logic [1:0]    we_c;

  ariane_regfile_lvt u_a (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0), .clear_i(clear_a), .busy_o(busy_a),
    .raddr_i(raddr_a), .rdata_o(rdata_a), .waddr_i(waddr_a), .wdata_i(wdata_a), .we_i(we_a)
  );

  ariane_regfile_lvt #(.BYPASS(1'b0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0), .clear_i(clear_b), .busy_o(busy_b),
    .raddr_i(raddr_b), .rdata_o(rdata_b), .waddr_i(waddr_b), .wdata_i(wdata_b), .we_i(we_b)
  );

  ariane_regfile_lvt #(.NR_REGS(24), .ZERO_REG_ZERO(1'b1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0), .clear_i(clear_c), .busy_o(busy_c),
    .raddr_i(raddr_c), .rdata_o(rdata_c), .waddr_i(waddr_c), .wdata_i(wdata_c), .we_i(we_c)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    we_a = '0; we_b = '0; we_c = '0;
    clear_a = 1'b0; clear_b = 1'b0; clear_c = 1'b0;
    for (int i = 0; i < 2; i++) begin
      raddr_a[i] = '0; waddr_a[i] = '0; wdata_a[i] = '0;
      raddr_b[i] = '0; waddr_b[i] = '0; wdata_b[i] = '0;
      raddr_c[i] = '0; waddr_c[i] = '0; wdata_c[i] = '0;
    end
  endtask

  task automatic test_reset;
    logic [DW-1:0] exp0, exp1;
    rst_n = 1'b0;
    idle_all();
    repeat (3) tick();
    #2;
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_busy: got %0b expected 1", busy_a); end
    checks++;
    if (u_a.lvt_q[7] !== 1'b0) begin errors++; $display("FAIL reset_lvt: got %0b expected 0", u_a.lvt_q[7]); end
    tick();
    rst_n = 1'b1;
    #2;
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      if (n == 20) begin
        we_a = 2'b10; waddr_a[1] = 5'd4; wdata_a[1] = 64'hDEAD; raddr_a[0] = 5'd4;
        #1;
        checks++;
        if (rdata_a[0] !== '0) begin errors++; $display("FAIL busy_read_zero: got %0h expected 0", rdata_a[0]); end
      end
      tick();
      we_a = '0;
      #2;
    end
    checks++;
    if (n !== 32) begin errors++; $display("FAIL reset_clear_len: got %0d expected 32", n); end
    checks++;
    if (busy_c !== 1'b0) begin errors++; $display("FAIL reset_clear_c: got %0b expected 0", busy_c); end
    // first cycle after busy falls: write must be accepted
    we_a = 2'b01; waddr_a[0] = 5'd2; wdata_a[0] = 64'h77;
    tick();
    we_a = '0;
    for (int r = 0; r < 32; r++) begin
      raddr_a[0] = 5'(r);
      raddr_a[1] = 5'(31 - r);
      exp0 = (r == 2) ? 64'h77 : 64'h0;
      exp1 = (31 - r == 2) ? 64'h77 : 64'h0;
      #1;
      checks++;
      if (rdata_a[0] !== exp0 || rdata_a[1] !== exp1) begin
        errors++;
        $display("FAIL post_clear_reg%0d: got %0h/%0h expected %0h/%0h", r, rdata_a[0], rdata_a[1], exp0, exp1);
      end
    end
  endtask

  task automatic test_conflict_bypass;
    idle_all();
    we_a = 2'b11;
    waddr_a[0] = 5'd5; wdata_a[0] = 64'hA;
    waddr_a[1] = 5'd5; wdata_a[1] = 64'hB;
    raddr_a[0] = 5'd5;
    #2;
    checks++;
    if (rdata_a[0] !== 64'hB) begin errors++; $display("FAIL conflict_bypass: got %0h expected b", rdata_a[0]); end
    tick();
    we_a = '0;
    #2;
    checks++;
    if (rdata_a[0] !== 64'hB) begin errors++; $display("FAIL conflict_stored: got %0h expected b", rdata_a[0]); end
    checks++;
    if (u_a.lvt_q[5] !== 1'b1) begin errors++; $display("FAIL conflict_lvt: got %0b expected 1", u_a.lvt_q[5]); end
  endtask

  task automatic test_no_bypass;
    idle_all();
    we_b = 2'b01; waddr_b[0] = 5'd7; wdata_b[0] = 64'h1234;
    raddr_b[0] = 5'd7;
    #2;
    checks++;
    if (rdata_b[0] !== 64'h0) begin errors++; $display("FAIL nobypass_same: got %0h expected 0", rdata_b[0]); end
    tick();
    we_b = '0;
    #2;
    checks++;
    if (rdata_b[0] !== 64'h1234) begin errors++; $display("FAIL nobypass_next: got %0h expected 1234", rdata_b[0]); end
  endtask

  task automatic test_odd_zero;
    idle_all();
    we_c = 2'b01; waddr_c[0] = 5'd0; wdata_c[0] = 64'h99; raddr_c[0] = 5'd0;
    #2;
    checks++;
    if (rdata_c[0] !== 64'h0) begin errors++; $display("FAIL zero_reg_same: got %0h expected 0", rdata_c[0]); end
    tick();
    we_c = '0;
    #2;
    checks++;
    if (rdata_c[0] !== 64'h0) begin errors++; $display("FAIL zero_reg_next: got %0h expected 0", rdata_c[0]); end
    we_c = 2'b10; waddr_c[1] = 5'd30; wdata_c[1] = 64'h77; raddr_c[1] = 5'd30;
    #2;
    checks++;
    if (rdata_c[1] !== 64'h0) begin errors++; $display("FAIL oob_same: got %0h expected 0", rdata_c[1]); end
    tick();
    we_c = '0;
    #2;
    checks++;
    if (rdata_c[1] !== 64'h0) begin errors++; $display("FAIL oob_next: got %0h expected 0", rdata_c[1]); end
    we_c = 2'b01; waddr_c[0] = 5'd23; wdata_c[0] = 64'h55; raddr_c[0] = 5'd23;
    #2;
    checks++;
    if (rdata_c[0] !== 64'h55) begin errors++; $display("FAIL last_reg_bypass: got %0h expected 55", rdata_c[0]); end
    tick();
    we_c = '0;
    #2;
    checks++;
    if (rdata_c[0] !== 64'h55) begin errors++; $display("FAIL last_reg_next: got %0h expected 55", rdata_c[0]); end
  endtask

  task automatic test_cross_port;
    idle_all();
    we_a = 2'b10; waddr_a[1] = 5'd9; wdata_a[1] = 64'h11; raddr_a[0] = 5'd9;
    tick();
    we_a = '0;
    #1;
    checks++;
    if (rdata_a[0] !== 64'h11) begin errors++; $display("FAIL cross_first: got %0h expected 11", rdata_a[0]); end
    we_a = 2'b01; waddr_a[0] = 5'd9; wdata_a[0] = 64'h22;
    #1;
    checks++;
    if (rdata_a[0] !== 64'h22) begin errors++; $display("FAIL cross_bypass: got %0h expected 22", rdata_a[0]); end
    tick();
    we_a = '0;
    #2;
    checks++;
    if (rdata_a[0] !== 64'h22) begin errors++; $display("FAIL cross_stored: got %0h expected 22", rdata_a[0]); end
    checks++;
    if (u_a.lvt_q[9] !== 1'b0) begin errors++; $display("FAIL cross_lvt: got %0b expected 0", u_a.lvt_q[9]); end
  endtask

  task automatic test_clear;
    idle_all();
    we_a = 2'b01; waddr_a[0] = 5'd3; wdata_a[0] = 64'hFF; raddr_a[0] = 5'd3; raddr_a[1] = 5'd5;
    tick();
    we_a = '0;
    #1;
    checks++;
    if (rdata_a[0] !== 64'hFF) begin errors++; $display("FAIL clear_pre: got %0h expected ff", rdata_a[0]); end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL clear_pre_busy: got %0b expected 0", busy_a); end
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    #2;
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL clear_rise: got %0b expected 1", busy_a); end
    n = 1;
    while (n < 100) begin
      tick();
      clear_a = (n == 5);
      #2;
      if (!busy_a) break;
      n++;
    end
    clear_a = 1'b0;
    checks++;
    if (n !== 32) begin errors++; $display("FAIL clear_len: got %0d expected 32", n); end
    checks++;
    if (rdata_a[0] !== 64'h0) begin errors++; $display("FAIL clear_reg3: got %0h expected 0", rdata_a[0]); end
    checks++;
    if (rdata_a[1] !== 64'h0) begin errors++; $display("FAIL clear_reg5: got %0h expected 0", rdata_a[1]); end
  endtask

  task automatic test_reset_mid_clear;
    idle_all();
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    repeat (10) tick();
    #1;
    checks++;
    if (u_a.clr_cnt_q !== 5'd10) begin errors++; $display("FAIL mid_cnt: got %0d expected 10", u_a.clr_cnt_q); end
    rst_n = 1'b0;
    #2;
    checks++;
    if (busy_a !== 1'b1 || u_a.clr_cnt_q !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset_state: got busy=%0b cnt=%0d expected busy=1 cnt=0", busy_a, u_a.clr_cnt_q);
    end
    tick();
    rst_n = 1'b1;
    #2;
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      tick();
      #2;
    end
    checks++;
    if (n !== 32) begin errors++; $display("FAIL mid_reset_len: got %0d expected 32", n); end
  endtask

  initial begin
    test_reset();
    test_conflict_bypass();
    test_no_bypass();
    test_odd_zero();
    test_cross_port();
    test_clear();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
